// File: rtl/gpcfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpcfg_pkg                                              |
// | Description : Shared AHB encodings and the gpcfg_ahb_if FSM state    |
// |               encodings.                                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package gpcfg_pkg;

    // AHB transfer types
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // AHB transfer sizes supported by the register bus
    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    // Bus front-end FSM encodings
    localparam int         c_ST_W     = 3;
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WDATA = 3'd1;
    localparam logic [2:0] c_ST_RDATA = 3'd2;
    localparam logic [2:0] c_ST_RWAIT = 3'd3;
    localparam logic [2:0] c_ST_ERR1  = 3'd4;
    localparam logic [2:0] c_ST_ERR2  = 3'd5;

endpackage : gpcfg_pkg
`default_nettype wire

// File: rtl/gpcfg_ahb_if_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpcfg_ahb_if_if                                        |
// | Description : AHB-Lite slave-slot signal bundle for the gpcfg bus    |
// |               front end, with master and slave views.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface gpcfg_ahb_if_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    // Interconnect / master side: drives request and the bus-wide HREADY
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    // Slave side: the gpcfg front end
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

endinterface : gpcfg_ahb_if_if
`default_nettype wire

// File: rtl/gpcfg_ahb_bytedec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpcfg_ahb_bytedec                                      |
// | Description : Maps HSIZE and the low address bits onto register byte |
// |               lanes and flags unaligned or unsupported sizes.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gpcfg_ahb_bytedec
    import gpcfg_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_byte_en,
    output logic       o_misalign
);

    // Lane decode; sizes above a word are never legal on this bus
    always_comb begin
        o_byte_en  = 4'b0000;
        o_misalign = 1'b0;
        case (i_hsize)
            c_HSIZE_BYTE: begin
                o_byte_en = 4'b0001 << i_addr_lo;
            end
            c_HSIZE_HALF: begin
                o_byte_en  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            c_HSIZE_WORD: begin
                o_byte_en  = 4'b1111;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule : gpcfg_ahb_bytedec
`default_nettype wire

// File: rtl/gpcfg_ahb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpcfg_ahb_if                                           |
// | Description : AHB-Lite slave front end for the gpcfg register bus.   |
// |               Latches the address phase, strobes register writes /   |
// |               reads in the data phase and returns ERROR for illegal  |
// |               accesses.                                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gpcfg_ahb_if
    import gpcfg_pkg::*;
#(
    parameter bit          RD_WAIT    = 1'b0,
    parameter logic [15:0] ADDR_LIMIT = 16'h0100
)
(
    input  logic                  hclk,
    input  logic                  hresetn,
    gpcfg_ahb_if_if.slave         ahb,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [3:0]            byte_en,
    output logic [31:0]           wr_addr,
    output logic [31:0]           rd_addr,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata
);

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_nxt_state;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [3:0]        r_byte_en;
    logic [31:0]       r_wr_addr;
    logic [31:0]       r_rd_addr;
    logic              r_hreadyout;
    logic              r_hresp;

    logic [3:0]        w_byte_en;
    logic              w_misalign;
    logic              w_accept;
    logic              w_take;
    logic              w_illegal;

    gpcfg_ahb_bytedec u_bytedec (
        .i_hsize    (ahb.hsize),
        .i_addr_lo  (ahb.haddr[1:0]),
        .o_byte_en  (w_byte_en),
        .o_misalign (w_misalign)
    );

    assign w_accept  = ahb.hsel & ahb.hready &
                       ((ahb.htrans == c_HTRANS_NONSEQ) | (ahb.htrans == c_HTRANS_SEQ));
    // Stalled states own the bus; any accept seen there is not ours to take
    assign w_take    = w_accept & r_hreadyout;
    assign w_illegal = w_misalign | (ahb.haddr[15:0] >= ADDR_LIMIT);

    // Next state: the wait/error first halves always advance, every other state follows the new address phase
    always_comb begin
        w_nxt_state = c_ST_IDLE;
        case (r_state)
            c_ST_RWAIT: w_nxt_state = c_ST_RDATA;
            c_ST_ERR1:  w_nxt_state = c_ST_ERR2;
            default: begin
                if (w_take) begin
                    if (w_illegal)
                        w_nxt_state = c_ST_ERR1;
                    else if (ahb.hwrite)
                        w_nxt_state = c_ST_WDATA;
                    else
                        w_nxt_state = RD_WAIT ? c_ST_RWAIT : c_ST_RDATA;
                end
            end
        endcase
    end

    // State register plus all bus outputs registered from the next state
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= c_ST_IDLE;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_byte_en   <= 4'b0000;
            r_wr_addr   <= 32'h0;
            r_rd_addr   <= 32'h0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_wr_en     <= (w_nxt_state == c_ST_WDATA);
            r_rd_en     <= (w_nxt_state == c_ST_RDATA) | (w_nxt_state == c_ST_RWAIT);
            r_hreadyout <= ~((w_nxt_state == c_ST_RWAIT) | (w_nxt_state == c_ST_ERR1));
            r_hresp     <= (w_nxt_state == c_ST_ERR1) | (w_nxt_state == c_ST_ERR2);
            // Lanes are only live for the cycle the write strobe is up
            r_byte_en   <= (w_nxt_state == c_ST_WDATA) ? w_byte_en : 4'b0000;
            if (w_nxt_state == c_ST_WDATA)
                r_wr_addr <= {ahb.haddr[31:2], 2'b00};
            if (w_take & ~w_illegal & ~ahb.hwrite)
                r_rd_addr <= {ahb.haddr[31:2], 2'b00};
        end
    end

    generate
        if (RD_WAIT) begin : g_rd_wait
            logic [31:0] r_hrdata;

            // Capture register data during the wait cycle for a clean registered return
            always_ff @(posedge hclk or negedge hresetn) begin
                if (!hresetn)
                    r_hrdata <= 32'h0;
                else if (r_state == c_ST_RWAIT)
                    r_hrdata <= rdata;
            end

            assign ahb.hrdata = r_hrdata;
        end else begin : g_rd_nowait
            assign ahb.hrdata = r_rd_en ? rdata : 32'h0;
        end
    endgenerate

    assign ahb.hreadyout = r_hreadyout;
    assign ahb.hresp     = r_hresp;
    assign wr_en         = r_wr_en;
    assign rd_en         = r_rd_en;
    assign byte_en       = r_byte_en;
    assign wr_addr       = r_wr_addr;
    assign rd_addr       = r_rd_addr;
    assign wdata         = r_wr_en ? ahb.hwdata : 32'h0;

endmodule : gpcfg_ahb_if
`default_nettype wire

// File: tb/tb_gpcfg_ahb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_gpcfg_ahb_if                                        |
// | Description : Bench for gpcfg_ahb_if: one zero-wait and one          |
// |               wait-state instance, each with two byte-writable       |
// |               registers at 0x0 and 0x4 whose read data is ORed.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_gpcfg_ahb_if;
    import gpcfg_pkg::*;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;
    logic por     = 1'b1;

    always #5 hclk = ~hclk;

    // Shared master request, steered to one instance at a time
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic        stall;
    int          sel;

    gpcfg_ahb_if_if bus0 ();
    gpcfg_ahb_if_if bus1 ();

    assign bus0.hsel   = m_hsel & (sel == 0);
    assign bus0.haddr  = m_haddr;
    assign bus0.htrans = m_htrans;
    assign bus0.hwrite = m_hwrite;
    assign bus0.hsize  = m_hsize;
    assign bus0.hwdata = m_hwdata;
    assign bus0.hready = bus0.hreadyout & ~stall;
    assign bus1.hsel   = m_hsel & (sel == 1);
    assign bus1.haddr  = m_haddr;
    assign bus1.htrans = m_htrans;
    assign bus1.hwrite = m_hwrite;
    assign bus1.hsize  = m_hsize;
    assign bus1.hwdata = m_hwdata;
    assign bus1.hready = bus1.hreadyout & ~stall;

    logic        wr_en0, rd_en0, wr_en1, rd_en1;
    logic [3:0]  byte_en0, byte_en1;
    logic [31:0] wr_addr0, rd_addr0, wdata0, rdata0;
    logic [31:0] wr_addr1, rd_addr1, wdata1, rdata1;

    gpcfg_ahb_if #(.RD_WAIT(1'b0), .ADDR_LIMIT(16'h0100)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .ahb(bus0),
        .wr_en(wr_en0), .rd_en(rd_en0), .byte_en(byte_en0),
        .wr_addr(wr_addr0), .rd_addr(rd_addr0), .wdata(wdata0), .rdata(rdata0)
    );

    gpcfg_ahb_if #(.RD_WAIT(1'b1), .ADDR_LIMIT(16'h0100)) dut1 (
        .hclk(hclk), .hresetn(hresetn), .ahb(bus1),
        .wr_en(wr_en1), .rd_en(rd_en1), .byte_en(byte_en1),
        .wr_addr(wr_addr1), .rd_addr(rd_addr1), .wdata(wdata1), .rdata(rdata1)
    );

    // Register array behind each instance (not cleared by hresetn)
    logic [31:0] regs0 [2];
    logic [31:0] regs1 [2];

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    // Byte-enabled register updates on the write strobe
    always @(posedge hclk) begin
        if (por) begin
            regs0[0] <= 32'h0; regs0[1] <= 32'h0;
            regs1[0] <= 32'h0; regs1[1] <= 32'h0;
        end else begin
            if (wr_en0 && wr_addr0 == 32'h0) regs0[0] <= merge(regs0[0], wdata0, byte_en0);
            if (wr_en0 && wr_addr0 == 32'h4) regs0[1] <= merge(regs0[1], wdata0, byte_en0);
            if (wr_en1 && wr_addr1 == 32'h0) regs1[0] <= merge(regs1[0], wdata1, byte_en1);
            if (wr_en1 && wr_addr1 == 32'h4) regs1[1] <= merge(regs1[1], wdata1, byte_en1);
        end
    end

    assign rdata0 = rd_en0 ? (((rd_addr0 == 32'h0) ? regs0[0] : 32'h0) |
                              ((rd_addr0 == 32'h4) ? regs0[1] : 32'h0)) : 32'h0;
    assign rdata1 = rd_en1 ? (((rd_addr1 == 32'h0) ? regs1[0] : 32'h0) |
                              ((rd_addr1 == 32'h4) ? regs1[1] : 32'h0)) : 32'h0;

    // Strobe counters
    int wr_cnt0 = 0, rd_cnt1 = 0;
    always @(posedge hclk) begin
        wr_cnt0 <= wr_cnt0 + (wr_en0 ? 1 : 0);
        rd_cnt1 <= rd_cnt1 + (rd_en1 ? 1 : 0);
    end

    // View of the currently selected instance
    logic        s_hreadyout, s_hresp, s_wr_en;
    logic [31:0] s_hrdata, s_wr_addr;
    logic [3:0]  s_byte_en;
    always_comb begin
        s_hreadyout = bus0.hreadyout;
        s_hresp     = bus0.hresp;
        s_hrdata    = bus0.hrdata;
        s_wr_en     = wr_en0;
        s_wr_addr   = wr_addr0;
        s_byte_en   = byte_en0;
        if (sel == 1) begin
            s_hreadyout = bus1.hreadyout;
            s_hresp     = bus1.hresp;
            s_hrdata    = bus1.hrdata;
            s_wr_en     = wr_en1;
            s_wr_addr   = wr_addr1;
            s_byte_en   = byte_en1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference contents and scoreboard of expected read data
    logic [31:0] mdl [2][2];
    logic [31:0] exp_q [$];
    logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0;
    logic [31:0] dp_wdata = 32'h0;
    int          last_waits = 0;

    function automatic logic is_bad(input logic [31:0] a, input logic [2:0] sz);
        return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00) ||
               (a[15:0] >= 16'h0100);
    endfunction

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
        if (sz == 3'd0) return 4'b0001 << a[1:0];
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // One address phase (valid=0 gives an IDLE slot), completing the pending data phase
    task automatic step(input logic valid, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input int stall_cyc);
        logic rdy;
        logic ill;
        int   guard;
        ill      = valid && is_bad(a, sz);
        m_hsel   = valid;
        m_htrans = valid ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
        m_haddr  = a;
        m_hwrite = wr;
        m_hsize  = sz;
        m_hwdata = dp_wdata;
        stall    = (stall_cyc > 0);
        if (valid && !ill) begin
            if (wr) begin
                if (a[31:3] == 29'h0) mdl[sel][a[2]] = merge(mdl[sel][a[2]], wd, lanes(a, sz));
            end else begin
                exp_q.push_back((a[31:3] == 29'h0) ? mdl[sel][a[2]] : 32'h0);
            end
        end
        guard = 0;
        last_waits = 0;
        rdy = 1'b0;
        while (!rdy) begin
            @(negedge hclk);
            rdy = s_hreadyout && !stall;
            if (!rdy && !stall) last_waits++;
            if (dp_valid && dp_err) begin
                check_eq("err_hresp", {31'h0, s_hresp}, 32'd1);
            end else if (rdy && dp_valid && !dp_write) begin
                check_eq("rd_data", s_hrdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx);
                check_eq("rd_resp", {31'h0, s_hresp}, 32'd0);
            end
            @(posedge hclk);
            #1;
            if (stall_cyc > 0) begin
                stall_cyc--;
                stall = (stall_cyc > 0);
            end
            guard++;
            if (!rdy && guard > 20) begin
                check_eq("hready_timeout", {31'h0, rdy}, 32'd1);
                break;
            end
        end
        if (valid && !ill && wr) begin
            check_eq("wr_en", {31'h0, s_wr_en}, 32'd1);
            check_eq("byte_en", {28'h0, s_byte_en}, {28'h0, lanes(a, sz)});
            check_eq("wr_addr", s_wr_addr, {a[31:2], 2'b00});
        end
        if (ill) begin
            check_eq("err1_ready", {31'h0, s_hreadyout}, 32'd0);
            check_eq("err1_resp", {31'h0, s_hresp}, 32'd1);
        end
        dp_valid = valid;
        dp_write = wr;
        dp_err   = ill;
        dp_wdata = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, c_HSIZE_WORD, 32'h0, 0);
    endtask

    int base;

    // Directed sequences
    initial begin
        m_hsel = 1'b0; m_haddr = 32'h0; m_htrans = c_HTRANS_IDLE; m_hwrite = 1'b0;
        m_hsize = c_HSIZE_WORD; m_hwdata = 32'h0; stall = 1'b0; sel = 0;
        for (int k = 0; k < 2; k++) begin mdl[k][0] = 32'h0; mdl[k][1] = 32'h0; end
        repeat (2) @(posedge hclk);
        #1;
        check_eq("rst_hreadyout", {31'h0, bus0.hreadyout}, 32'd1);
        check_eq("rst_hresp", {31'h0, bus0.hresp}, 32'd0);
        check_eq("rst_hrdata", bus0.hrdata, 32'h0);
        check_eq("rst_wr_en", {31'h0, wr_en0}, 32'd0);
        check_eq("rst_rd_en", {31'h0, rd_en0}, 32'd0);
        check_eq("rst_byte_en", {28'h0, byte_en0}, 32'd0);
        check_eq("rst_wr_addr", wr_addr0, 32'h0);
        check_eq("rst_rd_addr", rd_addr0, 32'h0);
        por = 1'b0;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Word write then read
        base = wr_cnt0;
        step(1'b1, 1'b1, 32'h4, c_HSIZE_WORD, 32'hDEADBEEF, 0);
        step(1'b1, 1'b0, 32'h4, c_HSIZE_WORD, 32'h0, 0);
        idle(2);
        check_eq("wr_strobes", wr_cnt0 - base, 32'd1);

        // Byte write on lane 2 over a cleared word
        step(1'b1, 1'b1, 32'h4, c_HSIZE_WORD, 32'h0, 0);
        step(1'b1, 1'b1, 32'h6, c_HSIZE_BYTE, 32'h00AA0000, 0);
        step(1'b1, 1'b0, 32'h4, c_HSIZE_WORD, 32'h0, 0);
        idle(1);

        // Misaligned halfword write is rejected and leaves the register alone
        step(1'b1, 1'b1, 32'h0, c_HSIZE_WORD, 32'hCAFEF00D, 0);
        idle(1);
        base = wr_cnt0;
        step(1'b1, 1'b1, 32'h1, c_HSIZE_HALF, 32'hFFFFFFFF, 0);
        idle(2);
        check_eq("err_no_write", wr_cnt0 - base, 32'd0);
        step(1'b1, 1'b0, 32'h0, c_HSIZE_WORD, 32'h0, 0);
        idle(1);

        // Pipelined write then read of the same register
        step(1'b1, 1'b1, 32'h0, c_HSIZE_WORD, 32'h12345678, 0);
        step(1'b1, 1'b0, 32'h0, c_HSIZE_WORD, 32'h0, 0);
        idle(1);

        // Address limit boundary and oversize transfer
        step(1'b1, 1'b0, 32'hFC, c_HSIZE_WORD, 32'h0, 0);
        step(1'b1, 1'b0, 32'h100, c_HSIZE_WORD, 32'h0, 0);
        step(1'b1, 1'b0, 32'h0, 3'd3, 32'h0, 0);
        idle(2);

        // Wait-state instance: one stall cycle, then no duplicate strobes under hready=0
        sel = 1;
        step(1'b1, 1'b1, 32'h0, c_HSIZE_WORD, 32'h0BADC0DE, 0);
        step(1'b1, 1'b0, 32'h0, c_HSIZE_WORD, 32'h0, 0);
        idle(1);
        check_eq("rwait_cycles", last_waits, 32'd1);
        idle(1);
        base = rd_cnt1;
        step(1'b1, 1'b0, 32'h0, c_HSIZE_WORD, 32'h0, 2);
        idle(2);
        check_eq("rd_strobes", rd_cnt1 - base, 32'd2);
        sel = 0;
        idle(1);

        // Reset in the middle of a write data phase
        m_hsel = 1'b1; m_htrans = c_HTRANS_NONSEQ; m_haddr = 32'h4;
        m_hwrite = 1'b1; m_hsize = c_HSIZE_WORD;
        @(posedge hclk);
        #1;
        check_eq("pre_rst_wr_en", {31'h0, wr_en0}, 32'd1);
        m_hwdata = 32'h55555555; m_hsel = 1'b0; m_htrans = c_HTRANS_IDLE;
        hresetn = 1'b0;
        #1;
        check_eq("mid_rst_wr_en", {31'h0, wr_en0}, 32'd0);
        check_eq("mid_rst_byte_en", {28'h0, byte_en0}, 32'd0);
        check_eq("mid_rst_wr_addr", wr_addr0, 32'h0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        dp_valid = 1'b0; dp_err = 1'b0; dp_wdata = 32'h0;
        step(1'b1, 1'b0, 32'h4, c_HSIZE_WORD, 32'h0, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule : tb_gpcfg_ahb_if
`default_nettype wire
